// File: rtl/lstm_layer_scheduler_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lstm_sched_pkg : scheduler state codes, width defaults, helpers    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package lstm_sched_pkg;

  localparam int c_DATA_W_DEFAULT = 16;

  typedef logic [2:0] sched_state_t;

  localparam sched_state_t c_IDLE   = 3'd0;
  localparam sched_state_t c_ISSUE  = 3'd1;
  localparam sched_state_t c_WAIT   = 3'd2;
  localparam sched_state_t c_OUTPUT = 3'd3;
  localparam sched_state_t c_CLEAR  = 3'd4;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lstm_layer_scheduler_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lstm_layer_scheduler_if : control, sample and cell-datapath bundle |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface lstm_layer_scheduler_if
  import lstm_sched_pkg::*;
#(
  parameter int DATA_W = c_DATA_W_DEFAULT,
  parameter int LAYERS = 2
);
  localparam int LAYER_W = clog2_min1(LAYERS);

  logic               enable;
  logic               clear_state;
  logic [DATA_W-1:0]  x_in;
  logic               x_in_valid;
  logic               x_in_ready;
  logic               cell_start;
  logic               cell_clear;
  logic [LAYER_W-1:0] cell_layer;
  logic [DATA_W-1:0]  cell_x;
  logic               cell_done;
  logic [DATA_W-1:0]  cell_h;
  logic [DATA_W-1:0]  y_out;
  logic               y_out_valid;
  logic               busy;
  logic [31:0]        step_count;
  logic               error;

  modport master (
    input  enable, clear_state, x_in, x_in_valid, cell_done, cell_h,
    output x_in_ready, cell_start, cell_clear, cell_layer, cell_x,
           y_out, y_out_valid, busy, step_count, error
  );

  modport slave (
    output enable, clear_state, x_in, x_in_valid, cell_done, cell_h,
    input  x_in_ready, cell_start, cell_clear, cell_layer, cell_x,
           y_out, y_out_valid, busy, step_count, error
  );

endinterface
`default_nettype wire

// File: rtl/lstm_layer_scheduler_watchdog.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lstm_sched_watchdog : load/count/expire counter for cell_done wait |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module lstm_sched_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_load,
  input  wire logic i_count,
  output logic      o_expired
);
  localparam int c_CNT_W = $clog2(TIMEOUT + 1);

  logic [c_CNT_W-1:0] r_cnt;

  // Expires on the TIMEOUT-th counted cycle since the last load.
  assign o_expired = i_count && (r_cnt == c_CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || i_load) begin
      r_cnt <= '0;
    end else if (i_count && !o_expired) begin
      r_cnt <= r_cnt + c_CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/lstm_layer_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lstm_layer_scheduler : sequences one shared LSTM cell over LAYERS  |
// | layers per sample. Option macro: LSTM_SCHED_TIMEOUT_EN. Rev 1.0    |
// +--------------------------------------------------------------------+
module lstm_layer_scheduler
  import lstm_sched_pkg::*;
#(
  parameter int DATA_W  = c_DATA_W_DEFAULT,
  parameter int LAYERS  = 2,
  parameter int TIMEOUT = 1024
) (
  input  wire logic               clk,
  input  wire logic               rst,
  lstm_layer_scheduler_if.master  bus
);
  localparam int LAYER_W = clog2_min1(LAYERS);

  sched_state_t       r_state;
  logic [LAYER_W-1:0] r_layer;
  logic [DATA_W-1:0]  r_cur;
  logic [DATA_W-1:0]  r_y;
  logic [31:0]        r_steps;
  logic               r_clear_pend;
  logic               r_error;

  logic w_last;
  logic w_accept;
  logic w_expired;

  assign w_last   = (r_layer == LAYER_W'(LAYERS - 1));
  assign w_accept = bus.x_in_valid && bus.x_in_ready;

  // A clear request in the same cycle wins over a new sample.
  assign bus.x_in_ready  = (r_state == c_IDLE) && bus.enable && !r_clear_pend && !bus.clear_state;
  assign bus.cell_start  = (r_state == c_ISSUE);
  assign bus.cell_clear  = (r_state == c_CLEAR);
  assign bus.cell_layer  = r_layer;
  assign bus.cell_x      = r_cur;
  assign bus.y_out       = r_y;
  assign bus.y_out_valid = (r_state == c_OUTPUT);
  assign bus.busy        = (r_state != c_IDLE);
  assign bus.step_count  = r_steps;
  assign bus.error       = r_error;

`ifdef LSTM_SCHED_TIMEOUT_EN
  lstm_sched_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .i_load    (r_state == c_ISSUE),
    .i_count   (r_state == c_WAIT),
    .o_expired (w_expired)
  );
`else
  assign w_expired = 1'b0;

  generate
    if (TIMEOUT < 1) begin : g_timeout_unused
      // TIMEOUT only matters when the watchdog is built in.
    end
  endgenerate
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= c_IDLE;
      r_layer      <= '0;
      r_cur        <= '0;
      r_y          <= '0;
      r_steps      <= '0;
      r_clear_pend <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      if (bus.clear_state && (r_state != c_IDLE)) begin
        r_clear_pend <= 1'b1;
      end
      case (r_state)
        c_IDLE: begin
          if (r_clear_pend || bus.clear_state) begin
            r_layer <= '0;
            r_state <= c_CLEAR;
          end else if (w_accept) begin
            r_cur   <= bus.x_in;
            r_layer <= '0;
            r_state <= c_ISSUE;
          end
        end
        c_ISSUE: r_state <= c_WAIT;
        c_WAIT: begin
          if (bus.cell_done) begin
            r_cur <= bus.cell_h;
            if (w_last) begin
              r_y     <= bus.cell_h;
              r_state <= c_OUTPUT;
            end else begin
              r_layer <= r_layer + LAYER_W'(1);
              r_state <= c_ISSUE;
            end
          end else if (w_expired) begin
            r_error <= 1'b1;
            r_layer <= '0;
            r_state <= c_IDLE;
          end
        end
        c_OUTPUT: begin
          r_steps <= r_steps + 32'd1;
          r_layer <= '0;
          r_state <= c_IDLE;
        end
        c_CLEAR: begin
          if (w_last) begin
            // A request arriving on the final clear cycle re-arms the pending flag.
            r_clear_pend <= bus.clear_state;
            r_error      <= 1'b0;
            r_layer      <= '0;
            r_state      <= c_IDLE;
          end else begin
            r_layer <= r_layer + LAYER_W'(1);
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lstm_layer_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_lstm_layer_scheduler : self-checking bench, cell model h = x+1  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_lstm_layer_scheduler;
  import lstm_sched_pkg::*;

  localparam int DATA_W  = 16;
  localparam int LAYERS  = 2;
  localparam int TIMEOUT = 8;
  localparam int D       = 3;

  typedef struct {
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] y;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lstm_layer_scheduler_if #(.DATA_W(DATA_W), .LAYERS(LAYERS)) bus ();

  lstm_layer_scheduler #(
    .DATA_W  (DATA_W),
    .LAYERS  (LAYERS),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rb_viol  = 0;

  int                start_cyc[$];
  logic [DATA_W-1:0] start_x[$];
  int                yv_cyc[$];
  int                clr_cyc[$];
  int                clr_layer[$];
  logic [DATA_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Cell model: done D cycles after start, h = x + 1; cell_en=0 models a hung cell.
  logic              cell_en = 1'b1;
  int                cell_cnt = 0;
  logic [DATA_W-1:0] cell_xl;
  initial begin
    bus.cell_done = 1'b0;
    bus.cell_h    = '0;
  end
  always @(negedge clk) begin
    bus.cell_done = 1'b0;
    if (cell_cnt > 0) begin
      cell_cnt--;
      if (cell_cnt == 0) begin
        bus.cell_done = 1'b1;
        bus.cell_h    = cell_xl + 16'd1;
      end
    end
    if (bus.cell_start && cell_en) begin
      cell_cnt = D;
      cell_xl  = bus.cell_x;
    end
  end

  // Monitor and scoreboard consumer.
  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (bus.busy && bus.x_in_ready) rb_viol++;
    if (bus.cell_start) begin
      start_cyc.push_back(cyc);
      start_x.push_back(bus.cell_x);
    end
    if (bus.cell_clear) begin
      clr_cyc.push_back(cyc);
      clr_layer.push_back(int'(bus.cell_layer));
    end
    if (bus.y_out_valid) begin
      yv_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL y_unexpected: y_out_valid with y_out=0x%0h, required no pulse", bus.y_out);
      end else begin
        check("y_out", bus.y_out, exp_q.pop_front());
      end
    end
  end

  task automatic at_cycle(input int c);
    while (cyc < c) @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y,
                      input bit keep, output int acc);
    int g = 0;
    @(negedge clk);
    bus.x_in       = x;
    bus.x_in_valid = 1'b1;
    #1;
    while (!bus.x_in_ready && g < 300) begin
      @(negedge clk);
      #1;
      g++;
    end
    acc = cyc;
    if (!bus.x_in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: x_in_ready stayed 0, required 1 within 300 cycles");
    end else begin
      exp_q.push_back(y);
    end
    if (!keep) begin
      @(negedge clk);
      bus.x_in_valid = 1'b0;
    end
  endtask

  task automatic wait_y(input int n);
    int g = 0;
    while (yv_cyc.size() < n && g < 300) begin
      @(negedge clk);
      g++;
    end
    check("y_pulse_count", yv_cyc.size(), n);
  endtask

  vec_t tbl[5];
  int   acc, acc2, base, s0, steps;

  initial begin
    tbl[0] = '{x: 16'h0010, y: 16'h0012};
    tbl[1] = '{x: 16'hFFFF, y: 16'h0001};
    tbl[2] = '{x: 16'h7FFF, y: 16'h8001};
    tbl[3] = '{x: 16'h0000, y: 16'h0002};
    tbl[4] = '{x: 16'h1234, y: 16'h1236};

    bus.enable      = 1'b0;
    bus.clear_state = 1'b0;
    bus.x_in        = '0;
    bus.x_in_valid  = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy",        bus.busy,        0);
    check("rst_ready",       bus.x_in_ready,  0);
    check("rst_cell_start",  bus.cell_start,  0);
    check("rst_cell_clear",  bus.cell_clear,  0);
    check("rst_cell_layer",  bus.cell_layer,  0);
    check("rst_cell_x",      bus.cell_x,      0);
    check("rst_y_out",       bus.y_out,       0);
    check("rst_y_valid",     bus.y_out_valid, 0);
    check("rst_step_count",  bus.step_count,  0);
    check("rst_error",       bus.error,       0);
    rst        = 1'b0;
    bus.enable = 1'b1;

    // Table vectors; entry 0 also checks the exact latency profile.
    for (int i = 0; i < 5; i++) begin
      base = start_cyc.size();
      s0   = yv_cyc.size();
      send(tbl[i].x, tbl[i].y, 1'b0, acc);
      wait_y(s0 + 1);
      check("y_latency", yv_cyc[s0] - acc, 2 * (D + 1) + 1);
      if (i == 0) begin
        check("start0_cycle", start_cyc[base] - acc, 1);
        check("start1_cycle", start_cyc[base + 1] - acc, D + 2);
        check("start0_x", start_x[base], 16'h0010);
        check("start1_x", start_x[base + 1], 16'h0011);
        @(negedge clk);
        check("step_after_first", bus.step_count, 1);
      end
    end
    @(negedge clk);
    check("step_after_table", bus.step_count, 5);

    // Back-to-back with x_in_valid held high.
    s0 = yv_cyc.size();
    send(16'h0100, 16'h0102, 1'b1, acc);
    send(16'h0200, 16'h0202, 1'b1, acc);
    send(16'h0300, 16'h0302, 1'b0, acc);
    wait_y(s0 + 3);
    check("b2b_gap01", yv_cyc[s0 + 1] - yv_cyc[s0], 10);
    check("b2b_gap12", yv_cyc[s0 + 2] - yv_cyc[s0 + 1], 10);
    @(negedge clk);
    check("b2b_steps", bus.step_count, 8);
    check("ready_low_while_busy", rb_viol, 0);

    // clear_state during WAIT: step completes, then CLEAR, then next sample.
    s0 = yv_cyc.size();
    send(16'h0400, 16'h0402, 1'b0, acc);
    at_cycle(acc + 2);
    check("clr_in_wait_busy", bus.busy, 1);
    bus.clear_state = 1'b1;
    bus.x_in        = 16'h0500;
    bus.x_in_valid  = 1'b1;
    at_cycle(acc + 3);
    bus.clear_state = 1'b0;
    send(16'h0500, 16'h0502, 1'b0, acc2);
    wait_y(s0 + 2);
    check("clr_step_done_cycle", yv_cyc[s0] - acc, 9);
    check("clr_pulses", clr_cyc.size(), 2);
    if (clr_cyc.size() == 2) begin
      check("clr0_cycle", clr_cyc[0] - acc, 11);
      check("clr1_cycle", clr_cyc[1] - acc, 12);
      check("clr0_layer", clr_layer[0], 0);
      check("clr1_layer", clr_layer[1], 1);
    end
    check("accept_after_clear", acc2 - acc, 13);

    // Disabled: no acceptance, no activity.
    @(negedge clk);
    base = start_cyc.size();
    bus.enable     = 1'b0;
    bus.x_in       = 16'h0055;
    bus.x_in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("dis_ready", bus.x_in_ready, 0);
      check("dis_busy", bus.busy, 0);
      @(negedge clk);
    end
    check("dis_no_start", start_cyc.size(), base);
    bus.x_in_valid = 1'b0;
    bus.enable     = 1'b1;

    // Reset in WAIT; the late cell_done must not produce output.
    s0 = yv_cyc.size();
    send(16'h0600, 16'h0602, 1'b0, acc);
    void'(exp_q.pop_back());
    at_cycle(acc + 2);
    rst = 1'b1;
    at_cycle(acc + 3);
    check("mrst_busy",       bus.busy,        0);
    check("mrst_cell_start", bus.cell_start,  0);
    check("mrst_cell_x",     bus.cell_x,      0);
    check("mrst_y_out",      bus.y_out,       0);
    check("mrst_y_valid",    bus.y_out_valid, 0);
    check("mrst_step_count", bus.step_count,  0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("mrst_no_y", yv_cyc.size(), s0);
    check("mrst_idle", bus.busy, 0);

`ifdef LSTM_SCHED_TIMEOUT_EN
    // Hung cell: watchdog drops the sample and raises a sticky error.
    cell_en = 1'b0;
    s0 = yv_cyc.size();
    send(16'h0700, 16'h0702, 1'b0, acc);
    void'(exp_q.pop_back());
    at_cycle(acc + 9);
    check("to_still_waiting", bus.busy, 1);
    check("to_no_error_yet", bus.error, 0);
    at_cycle(acc + 10);
    check("to_idle", bus.busy, 0);
    check("to_error", bus.error, 1);
    check("to_steps", bus.step_count, 0);
    bus.clear_state = 1'b1;
    at_cycle(acc + 11);
    bus.clear_state = 1'b0;
    check("to_clear_pulse", bus.cell_clear, 1);
    at_cycle(acc + 13);
    check("to_error_cleared", bus.error, 0);
    check("to_no_y", yv_cyc.size(), s0);
    cell_en = 1'b1;
`else
    check("error_tied_low", bus.error, 0);
`endif

    steps = exp_q.size();
    check("scoreboard_empty", steps, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit, required completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
